// File: rtl/icache_intc_pkg.sv
// Shared defaults and helpers for the instruction-cache interconnect response path.
// Holds no state; only widths and the round-robin pointer wrap.
package icache_intc_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_N_CH       = 4;

   // Explicit wrap keeps the pointer legal for non-power-of-two channel counts
   function automatic int next_ptr(input int w, input int n);
      return (w == n - 1) ? 0 : w + 1;
   endfunction

endpackage

// File: rtl/rr_arb_comb_icache_intc.sv
// Combinational grant: round-robin from ptr (double-width masked scan) or fixed priority, highest index wins.
// Zero latency; grant is one-hot or zero and depends only on req and ptr.
module rr_arb_comb_icache_intc #(
   parameter int N_CH       = 4,
   parameter int FIXED_PRIO = 0,
   parameter int PTR_WIDTH  = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]      req,
   input  logic [PTR_WIDTH-1:0] ptr,
   output logic [N_CH-1:0]      grant
);

   logic [2*N_CH-1:0] req_dbl;
   logic [2*N_CH-1:0] req_msk;
   logic              found;
   int                idx;

   always_comb begin
      req_dbl = {req, req};
      req_msk = '0;
      grant   = '0;
      found   = 1'b0;
      idx     = 0;
      // Bits below ptr in the lower copy are masked; the upper copy supplies the wrap-around
      for (int i = 0; i < 2*N_CH; i++) begin
         if (i >= int'(ptr)) req_msk[i] = req_dbl[i];
      end
      if (FIXED_PRIO != 0) begin
         for (int i = 0; i < N_CH; i++) begin
            if (req[i]) begin
               grant    = '0;
               grant[i] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < 2*N_CH; i++) begin
            if (req_msk[i] && !found) begin
               found      = 1'b1;
               idx        = i % N_CH;
               grant[idx] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/resp_arb_rr_icache_intc.sv
// N-channel response arbiter into one output register; result appears one cycle after acceptance.
// Inputs are accepted only when the output register is empty or draining this cycle.
module resp_arb_rr_icache_intc
   import icache_intc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int N_CH       = DEF_N_CH,
   parameter int ID_WIDTH   = $clog2(N_CH),
   parameter int FIXED_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       resp_valid_i,
   input  logic [DATA_WIDTH-1:0] resp_data_i [N_CH-1:0],
   output logic [N_CH-1:0]       resp_ready_o,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_data_o,
   output logic [ID_WIDTH-1:0]   resp_id_o,
   input  logic                  resp_ready_i
);

   logic [N_CH-1:0]     req;
   logic [N_CH-1:0]     grant;
   logic [ID_WIDTH-1:0] rr_q;
   logic [ID_WIDTH-1:0] win_id;
   logic                load_en;
   logic                xfer;

   // Requests are masked while in reset so nothing can be accepted then
   assign req          = resp_valid_i & {N_CH{rst_n}};
   assign load_en      = ~resp_valid_o | resp_ready_i;
   assign resp_ready_o = grant & {N_CH{load_en}};
   assign xfer         = |resp_ready_o;

   rr_arb_comb_icache_intc #(
      .N_CH       (N_CH),
      .FIXED_PRIO (FIXED_PRIO),
      .PTR_WIDTH  (ID_WIDTH)
   ) u_arb (
      .req   (req),
      .ptr   (rr_q),
      .grant (grant)
   );

   always_comb begin
      win_id = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) win_id = ID_WIDTH'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else if (FIXED_PRIO == 0 && xfer) begin
         rr_q <= ID_WIDTH'(next_ptr(int'(win_id), N_CH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_o <= 1'b0;
         resp_data_o  <= '0;
         resp_id_o    <= '0;
      end else if (xfer) begin
         resp_valid_o <= 1'b1;
         resp_data_o  <= resp_data_i[win_id];
         resp_id_o    <= win_id;
      end else if (load_en) begin
         resp_valid_o <= 1'b0;
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(resp_ready_o));

   a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (resp_valid_o && !resp_ready_i) |=>
         (resp_valid_o && $stable(resp_data_o) && $stable(resp_id_o)));

   for (genvar g = 0; g < N_CH; g++) begin : g_in_stable
      a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
         (resp_valid_i[g] && !resp_ready_o[g]) |=>
            (!resp_valid_i[g] || $stable(resp_data_i[g])));
   end

endmodule
